// File: rtl/tamagotchi_v2.sv
// Core state machine of the virtual-pet game: game-tick generator, satiety/health
// decay and feeding/healing, and the pet mood register that feeds the display block.
module tamagotchi_v2 #(
  parameter int TICK_CYCLES = 1000,
  parameter int TEST_DIV    = 10,
  parameter int DECAY_TICKS = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       testBut,
  input  logic       feeding,
  input  logic       healing,
  output logic [2:0] state,
  output logic [2:0] satiety,
  output logic [2:0] health,
  output logic       tick,
  output logic       test_mode
);

  typedef enum logic [2:0] {
    NEUTRAL = 3'd0,
    HUNGRY  = 3'd1,
    SICK    = 3'd2,
    EATING  = 3'd3,
    HEALING = 3'd4,
    DEAD    = 3'd5
  } mood_e;

  localparam int CW = $clog2(TICK_CYCLES + 1);
  localparam int DW = $clog2(DECAY_TICKS + 1);
  localparam logic [CW-1:0] NORM_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(TICK_CYCLES / TEST_DIV - 1);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_TICKS - 1);

  logic [CW-1:0] cnt_r;
  logic [DW-1:0] dcnt_r;
  logic [DW-1:0] dcnt_nxt_s;
  logic [2:0]    satiety_r;
  logic [2:0]    health_r;
  logic [2:0]    sat_nxt_s;
  logic [2:0]    hp_nxt_s;
  logic          tick_r;
  logic          test_mode_r;
  logic          mode_chg_s;
  logic          cnt_last_s;
  logic          upd_s;
  mood_e         state_r;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

  function automatic mood_e next_mood(input logic [2:0] hp, input logic [2:0] sat,
                                      input logic fd, input logic hl);
    mood_e m;
    if (hp == 3'd0)       m = DEAD;
    else if (fd)          m = EATING;
    else if (hl)          m = HEALING;
    else if (hp <= 3'd2)  m = SICK;
    else if (sat <= 3'd2) m = HUNGRY;
    else                  m = NEUTRAL;
    return m;
  endfunction

  // Tick-period terminal count and test-mode change detection
  always_comb begin
    mode_chg_s = (testBut != test_mode_r);
    if (test_mode_r) cnt_last_s = (cnt_r == FAST_LAST);
    else             cnt_last_s = (cnt_r == NORM_LAST);
  end

  // Tick generator; a mode change restarts the period without emitting a tick
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_r       <= '0;
      tick_r      <= 1'b0;
      test_mode_r <= 1'b0;
    end else if (mode_chg_s) begin
      cnt_r       <= '0;
      tick_r      <= 1'b0;
      test_mode_r <= testBut;
    end else if (cnt_last_s) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
      tick_r <= 1'b0;
    end
  end

  // Next stat values; a held button shields its own stat from decay
  always_comb begin
    upd_s      = tick_r && (state_r != DEAD);
    sat_nxt_s  = satiety_r;
    hp_nxt_s   = health_r;
    dcnt_nxt_s = dcnt_r;
    if (upd_s) begin
      if (feeding) begin
        sat_nxt_s  = sat_inc(satiety_r);
        dcnt_nxt_s = '0;
      end else if (dcnt_r == DECAY_LAST) begin
        dcnt_nxt_s = '0;
        if (satiety_r != 3'd0) sat_nxt_s = satiety_r - 3'd1;
        else if (!healing)     hp_nxt_s  = sat_dec(health_r);
        else                   hp_nxt_s  = health_r;
      end else begin
        dcnt_nxt_s = dcnt_r + DW'(1);
      end
      if (healing) hp_nxt_s = sat_inc(health_r);
      else         hp_nxt_s = hp_nxt_s;
    end else begin
      dcnt_nxt_s = dcnt_r;
    end
  end

  // Stat and decay-counter registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      satiety_r <= 3'd7;
      health_r  <= 3'd7;
      dcnt_r    <= '0;
    end else begin
      satiety_r <= sat_nxt_s;
      health_r  <= hp_nxt_s;
      dcnt_r    <= dcnt_nxt_s;
    end
  end

  // Mood register; DEAD holds until reset
  always_ff @(posedge Clk) begin
    if (Rst)                  state_r <= NEUTRAL;
    else if (state_r == DEAD) state_r <= DEAD;
    else                      state_r <= next_mood(health_r, satiety_r, feeding, healing);
  end

  assign state     = state_r;
  assign satiety   = satiety_r;
  assign health    = health_r;
  assign tick      = tick_r;
  assign test_mode = test_mode_r;

endmodule

// File: tb/tb_tamagotchi_v2.sv
// Scoreboard bench for tamagotchi_v2: directed scenarios plus random button/mode
// segments, checked every cycle against an integer reference model of the pet rules.
module tb_tamagotchi_v2;

  localparam int TC = 10;
  localparam int TD = 5;
  localparam int DK = 2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       testBut = 1'b0;
  logic       feeding = 1'b0;
  logic       healing = 1'b0;
  logic [2:0] state, satiety, health;
  logic       tick, test_mode;

  tamagotchi_v2 #(.TICK_CYCLES(TC), .TEST_DIV(TD), .DECAY_TICKS(DK)) dut (
    .Clk(Clk), .Rst(Rst), .testBut(testBut), .feeding(feeding), .healing(healing),
    .state(state), .satiety(satiety), .health(health), .tick(tick), .test_mode(test_mode)
  );

  always #5 Clk = ~Clk;

  logic [10:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // reference model: plain integers following the game rules
  int m_sat = 7, m_hp = 7, m_mood = 0, m_tick = 0, m_tm = 0, m_phase = 0, m_ticks_since_decay = 0;

  task automatic model_step();
    int nm, ns, nh;
    if (Rst) begin
      m_sat = 7; m_hp = 7; m_mood = 0; m_tick = 0; m_tm = 0; m_phase = 0;
      m_ticks_since_decay = 0;
    end else begin
      if (m_mood == 5 || m_hp == 0) nm = 5;
      else if (feeding)             nm = 3;
      else if (healing)             nm = 4;
      else if (m_hp <= 2)           nm = 2;
      else if (m_sat <= 2)          nm = 1;
      else                          nm = 0;
      ns = m_sat;
      nh = m_hp;
      if (m_tick == 1 && m_mood != 5) begin
        if (feeding) begin
          ns = (m_sat < 7) ? m_sat + 1 : 7;
          m_ticks_since_decay = 0;
        end else begin
          m_ticks_since_decay++;
          if (m_ticks_since_decay == DK) begin
            m_ticks_since_decay = 0;
            if (m_sat > 0)     ns = m_sat - 1;
            else if (!healing) nh = (m_hp > 0) ? m_hp - 1 : 0;
          end
        end
        if (healing) nh = (m_hp < 7) ? m_hp + 1 : 7;
      end
      if (int'(testBut) != m_tm) begin
        m_tm = int'(testBut);
        m_phase = 0;
        m_tick = 0;
      end else begin
        m_phase++;
        if (m_phase == (m_tm == 1 ? TC / TD : TC)) begin
          m_tick = 1;
          m_phase = 0;
        end else begin
          m_tick = 0;
        end
      end
      m_sat = ns;
      m_hp = nh;
      m_mood = nm;
    end
    exp_q.push_back({3'(m_mood), 3'(m_sat), 3'(m_hp), 1'(m_tick), 1'(m_tm)});
  endtask

  task automatic drive(input logic r, input logic tb, input logic fd, input logic hl);
    @(negedge Clk);
    Rst = r; testBut = tb; feeding = fd; healing = hl;
    @(posedge Clk);
    model_step();
  endtask

  // monitor: one expected output vector per clock, compared away from the edge
  always @(negedge Clk) begin
    logic [10:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, satiety, health, tick, test_mode};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t got st=%0d sat=%0d hp=%0d tick=%0b tm=%0b expected st=%0d sat=%0d hp=%0d tick=%0b tm=%0b",
                 $time, a[10:8], a[7:5], a[4:2], a[1], a[0], e[10:8], e[7:5], e[4:2], e[1], e[0]);
      end
    end
  end

  initial begin
    int len;
    logic tb, fd, hl, r;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (25) drive(1'b0, 1'b0, 1'b0, 1'b0);
    // toggle into fast mode mid-count in normal mode
    repeat (1) drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (70) drive(1'b0, 1'b1, 1'b0, 1'b0);
    // buttons while dead
    repeat (30) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    // starve down to satiety 3, then feed for 6+ ticks
    repeat (16) drive(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (14) drive(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b0);
    // drain satiety to 0 and health low, then heal
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (48) drive(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (16) drive(1'b0, 1'b1, 1'b0, 1'b1);
    tb = 1'b1;
    for (int s = 0; s < 160; s++) begin
      len = $urandom_range(1, 20);
      if ($urandom_range(0, 7) == 0) tb = ~tb;
      fd = ($urandom_range(0, 2) == 0);
      hl = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 30) == 0);
      drive(r, tb, fd, hl);
      repeat (len - 1) drive(1'b0, tb, fd, hl);
    end
    @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tamagotchi_v2.md
Name: tamagotchi_v2

Overview:
- Core state machine of the virtual-pet game.
- Derives a game tick from the system clock; normal rate, or a fast rate while testBut is held.
- Decays two stats (satiety, health) on ticks and raises them from the feeding/healing buttons.
- Exposes a pet mood state plus stat levels to the display/visual block downstream.

Parameters:
- TICK_CYCLES, 1000: clock cycles per game tick in normal mode; must be divisible by TEST_DIV.
- TEST_DIV, 10: speed-up factor while testBut=1; fast period = TICK_CYCLES/TEST_DIV.
- DECAY_TICKS, 4: ticks between successive decrements of a decaying stat.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- testBut  in  1  level; 1 = fast tick (test mode).
- feeding  in  1  level; held = feeding the pet.
- healing  in  1  level; held = healing the pet.
- state  out  3  mood: 0 NEUTRAL, 1 HUNGRY, 2 SICK, 3 EATING, 4 HEALING, 5 DEAD.
- satiety  out  3  satiety level 0..7.
- health  out  3  health level 0..7.
- tick  out  1  one-cycle game-tick pulse.
- test_mode  out  1  registered copy of testBut.

Behaviour:
- All inputs are synchronous to Clk; no synchronizers.
- Reset (Rst=1 at an edge, highest priority, valid mid-operation) sets:
  - satiety=7, health=7, state=NEUTRAL;
  - tick=0, test_mode=0;
  - tick counter=0, decay counter=0.
- Tick generator:
  - period P = TICK_CYCLES, or TICK_CYCLES/TEST_DIV when test_mode=1.
  - Counter counts 0..P-1. tick is registered high for exactly one cycle after the counter reaches P-1, then the counter wraps to 0.
  - First tick is high on the P-th cycle after reset release.
  - When test_mode changes value, the counter clears to 0 and no tick is issued on that cycle.
- Stat update: only on edges where tick=1 and state!=DEAD. Results are visible on the next cycle.
  - feeding=1: satiety+1, saturating at 7.
  - healing=1: health+1, saturating at 7.
  - Both buttons high: both increments apply.
  - Decay counter (0..DECAY_TICKS-1) advances on every tick with feeding=0. It is cleared on any tick with feeding=1.
  - On wrap of the decay counter:
    - if satiety>0: satiety-1;
    - else if healing=0: health-1, saturating at 0.
  - A held button suppresses decay of its own stat on that tick.
- State register, updated every cycle from current inputs and stats, in priority order:
  - DEAD if health==0;
  - else EATING if feeding;
  - else HEALING if healing;
  - else SICK if health<=2;
  - else HUNGRY if satiety<=2;
  - else NEUTRAL.
- DEAD is absorbing:
  - stats and decay counter freeze;
  - buttons are ignored;
  - tick keeps running;
  - only Rst exits DEAD.
- Intended size: ~150-250 lines.

Test Plan:
(all with TICK_CYCLES=10, TEST_DIV=5, DECAY_TICKS=2)
1. Hold Rst=1 for 3 cycles, then release; no buttons -> satiety=7, health=7, state=0; tick first high 10 cycles after release, then every 10 cycles.
2. testBut=1, no buttons -> tick every 2 cycles, test_mode=1. Satiety steps down every 2 ticks: state=HUNGRY(1) at satiety=2 after 10 ticks. Satiety reaches 0 after 14 ticks; health then falls every 2 ticks; state=SICK(2) at health=2; state=DEAD(5) at health=0 after 28 ticks total.
3. From satiety=3, hold feeding for 6 ticks -> state=EATING(3) immediately. Satiety 3→7, saturating with no wrap. Release -> state=NEUTRAL, decay counter restarted.
4. With health=2, satiety=0, hold healing -> state=HEALING(4). Health rises 1 per tick to 7. Satiety stays 0, and health does not decay while healing is held.
5. In DEAD, pulse feeding/healing over several ticks -> stats unchanged, state stays 5. Assert Rst -> next cycle satiety=7, health=7, state=0.
6. Toggle testBut mid-count (counter=6, normal mode) -> no tick on the toggle cycle; next tick exactly 2 cycles later.
